maxpooling1: RTL and testbench
==============================

MAXPOOLING1 -- requirements
Module: maxpooling1

Interface
REQ-001 Parameter: bitwidth, default 32, width of one feature-map element (two's complement).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: featuremap1  input  2*28*28*bitwidth  two 28x28 channels; element (c,row r,col k) at bit offset (c*784+28*k+r)*bitwidth.
REQ-005 Port: finished_from_previous_device  input  1  upstream convolution1 has valid featuremap1, held until acknowledged.
REQ-006 Port: reply_to_previous_device  output  1  one-cycle acknowledge that featuremap1 has been captured.
REQ-007 Port: reply_from_next_device  input  1  downstream stage has consumed featuremap2.
REQ-008 Port: featuremap2  output  2*14*14*bitwidth  pooled result; element (c,r,k) at bit offset (c*196+14*k+r)*bitwidth; registered.
REQ-009 Port: finished_for_next_device  output  1  featuremap2 valid; held until reply_from_next_device.

Function
REQ-010 Block SHALL implement a 4-state FSM: idle, capture, pool, finished.
REQ-011 idle -> capture when finished_from_previous_device=1; else stay idle.
REQ-012 capture: SHALL register all of featuremap1 into an internal buffer and assert reply_to_previous_device for exactly this one cycle; next state pool.
REQ-013 pool: SHALL compute one output row r (row counter 0..13) per cycle for both channels, all 14 columns; counter increments each pool cycle.
REQ-014 featuremap2(c,r,k) SHALL equal the signed maximum of buffer(c,2r,2k), (c,2r,2k+1), (c,2r+1,2k), (c,2r+1,2k+1).
REQ-015 Comparisons SHALL be signed bitwidth-bit; no saturation, no width growth; ties yield the common value.
REQ-016 pool -> finished after row 13 is written (14 pool cycles); row counter SHALL clear to 0 on leaving pool.
REQ-017 Latency: finished_for_next_device SHALL rise exactly 15 cycles after the cycle capture is entered.
REQ-018 finished_for_next_device SHALL be 1 exactly while in finished; featuremap2 SHALL not change while in finished.
REQ-019 finished: if reply_from_next_device=0 stay; if 1 and finished_from_previous_device=1 go to capture; if 1 and finished_from_previous_device=0 go to idle.
REQ-020 featuremap1 changes outside capture SHALL have no effect on the result being computed.
REQ-021 During pool, featuremap2 rows not yet rewritten SHALL retain prior values; only finished_for_next_device qualifies validity.
REQ-022 reply_from_next_device outside finished SHALL be ignored; finished_from_previous_device outside idle/finished SHALL be ignored.

Reset
REQ-023 On reset=1 at a rising edge: state idle, row counter 0, internal buffer 0, featuremap2 all 0, reply_to_previous_device 0, finished_for_next_device 0.
REQ-024 Reset SHALL take priority over every other input, including mid-pool and in finished; an in-flight frame is discarded.
REQ-025 First cycle after reset released SHALL behave as idle.

Structure
REQ-026 Shared package SHALL hold bitwidth default, feature-map dimensions (28, 14, channels 2) and the FSM state encoding, shared with convolution1.
REQ-027 One combinational sub-module max_of_four (four signed bitwidth inputs -> signed maximum) SHALL be instantiated 28 times (14 columns x 2 channels) for the current row.

Verification
REQ-028 Ramp: channel0 element=28*r+k, channel1 = negated; pulse frame -> ch0 out(r,k)=28*(2r+1)+2k+1, ch1 out(r,k)=-(56r+2k); finished 15 cycles after capture.
REQ-029 Handshake: hold finished_from_previous_device=1 -> reply_to_previous_device high exactly 1 cycle; hold reply_from_next_device=0 for 50 cycles -> finished and featuremap2 stable throughout.
REQ-030 Back-to-back: finished_from_previous_device=1 when reply_from_next_device=1 -> next cycle capture (no idle), second frame result correct.
REQ-031 Sign/ties: window {-5,-1,-3,-1} -> -1; window {0x7FFFFFFF,0x80000000,0,1} -> 0x7FFFFFFF; all-equal window 7 -> 7.
REQ-032 Reset at pool row 6 -> next cycle state idle, featuremap2 all 0, both handshake outputs 0; a fresh frame then completes correctly.
REQ-033 Change featuremap1 during pool -> output equals pooled captured frame, not the new data.

Source files
------------

// File: rtl/maxpooling1_pkg.sv
// Shared definitions for the convolution1 -> maxpooling1 pipeline: element width,
// feature-map geometry and the handshake FSM encoding.
package maxpooling1_pkg;

   localparam int BITWIDTH  = 32;
   localparam int FM1_DIM   = 28;
   localparam int FM2_DIM   = 14;
   localparam int CHANNELS  = 2;
   localparam int FM1_IDX_W = $clog2(FM1_DIM);
   localparam int FM2_IDX_W = $clog2(FM2_DIM);

   localparam logic [FM2_IDX_W-1:0] LAST_ROW = FM2_IDX_W'(FM2_DIM - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CAPTURE  = 2'd1,
      ST_POOL     = 2'd2,
      ST_FINISHED = 2'd3
   } state_t;

endpackage

// File: rtl/maxpooling1_max_of_four.sv
// Signed maximum of a 2x2 pooling window; ties naturally return the shared value.
module max_of_four
   import maxpooling1_pkg::*;
#(
   parameter int bitwidth = BITWIDTH
) (
   input  logic signed [bitwidth-1:0] a,
   input  logic signed [bitwidth-1:0] b,
   input  logic signed [bitwidth-1:0] c,
   input  logic signed [bitwidth-1:0] d,
   output logic signed [bitwidth-1:0] max_val
);

   logic signed [bitwidth-1:0] max_ab_s;
   logic signed [bitwidth-1:0] max_cd_s;

   // Pairwise reduction tree of signed comparisons
   always_comb begin
      max_ab_s = (a > b) ? a : b;
      max_cd_s = (c > d) ? c : d;
      max_val  = (max_ab_s > max_cd_s) ? max_ab_s : max_cd_s;
   end

endmodule

// File: rtl/maxpooling1.sv
// 2x2 max-pooling stage: captures a 2x28x28 frame, pools one output row per cycle
// for both channels, then holds the 2x14x14 result until downstream acknowledges.
module maxpooling1
   import maxpooling1_pkg::*;
#(
   parameter int bitwidth = BITWIDTH
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic [CHANNELS*FM1_DIM*FM1_DIM*bitwidth-1:0]  featuremap1,
   input  logic                                          finished_from_previous_device,
   output logic                                          reply_to_previous_device,
   input  logic                                          reply_from_next_device,
   output logic [CHANNELS*FM2_DIM*FM2_DIM*bitwidth-1:0]  featuremap2,
   output logic                                          finished_for_next_device
);

   state_t                 state_r;
   state_t                 state_next_s;
   logic [FM2_IDX_W-1:0]   row_r;
   logic                   reply_r;
   logic                   finished_r;

   // Arrays are indexed [channel][column][row] to mirror the flat port layout
   logic signed [bitwidth-1:0] fm1_s      [CHANNELS][FM1_DIM][FM1_DIM];
   logic signed [bitwidth-1:0] buf_r      [CHANNELS][FM1_DIM][FM1_DIM];
   logic signed [bitwidth-1:0] fm2_r      [CHANNELS][FM2_DIM][FM2_DIM];
   logic signed [bitwidth-1:0] pool_row_s [CHANNELS][FM2_DIM];

   for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_fm1_ch
      for (genvar gk = 0; gk < FM1_DIM; gk++) begin : g_fm1_col
         for (genvar gr = 0; gr < FM1_DIM; gr++) begin : g_fm1_row
            assign fm1_s[gc][gk][gr] =
               featuremap1[(gc*FM1_DIM*FM1_DIM + FM1_DIM*gk + gr)*bitwidth +: bitwidth];
         end
      end
   end

   for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_fm2_ch
      for (genvar gk = 0; gk < FM2_DIM; gk++) begin : g_fm2_col
         for (genvar gr = 0; gr < FM2_DIM; gr++) begin : g_fm2_row
            assign featuremap2[(gc*FM2_DIM*FM2_DIM + FM2_DIM*gk + gr)*bitwidth +: bitwidth] =
               fm2_r[gc][gk][gr];
         end
      end
   end

   // One comparator per output column per channel, fed from buffer rows 2r and 2r+1
   for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_pool_ch
      for (genvar gk = 0; gk < FM2_DIM; gk++) begin : g_pool_col
         max_of_four #(.bitwidth(bitwidth)) u_max (
            .a       (buf_r[gc][2*gk  ][{row_r, 1'b0}]),
            .b       (buf_r[gc][2*gk+1][{row_r, 1'b0}]),
            .c       (buf_r[gc][2*gk  ][{row_r, 1'b1}]),
            .d       (buf_r[gc][2*gk+1][{row_r, 1'b1}]),
            .max_val (pool_row_s[gc][gk])
         );
      end
   end

   // Next-state logic for the capture/pool/handshake sequence
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (finished_from_previous_device) begin
               state_next_s = ST_CAPTURE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_CAPTURE: begin
            state_next_s = ST_POOL;
         end
         ST_POOL: begin
            if (row_r == LAST_ROW) begin
               state_next_s = ST_FINISHED;
            end else begin
               state_next_s = ST_POOL;
            end
         end
         ST_FINISHED: begin
            if (!reply_from_next_device) begin
               state_next_s = ST_FINISHED;
            end else if (finished_from_previous_device) begin
               state_next_s = ST_CAPTURE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         row_r      <= '0;
         buf_r      <= '{default: '0};
         fm2_r      <= '{default: '0};
         reply_r    <= 1'b0;
         finished_r <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         reply_r    <= (state_next_s == ST_CAPTURE);
         finished_r <= (state_next_s == ST_FINISHED);
         if (state_r == ST_CAPTURE) begin
            buf_r <= fm1_s;
         end
         if (state_r == ST_POOL) begin
            for (int c = 0; c < CHANNELS; c++) begin
               for (int k = 0; k < FM2_DIM; k++) begin
                  fm2_r[c][k][row_r] <= pool_row_s[c][k];
               end
            end
            row_r <= (row_r == LAST_ROW) ? '0 : row_r + 1'b1;
         end else begin
            row_r <= '0;
         end
      end
   end

   assign reply_to_previous_device = reply_r;
   assign finished_for_next_device = finished_r;

endmodule

// File: tb/tb_maxpooling1.sv
// Directed scoreboard bench for maxpooling1: expected pooled frames are queued when a
// frame is offered and compared when the block signals completion.
module tb_maxpooling1;
   import maxpooling1_pkg::*;

   localparam int BW    = BITWIDTH;
   localparam int FM1_W = CHANNELS*FM1_DIM*FM1_DIM*BW;
   localparam int FM2_W = CHANNELS*FM2_DIM*FM2_DIM*BW;
   localparam int N_OUT = CHANNELS*FM2_DIM*FM2_DIM;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [FM1_W-1:0] featuremap1 = '0;
   logic             finished_from_previous_device = 1'b0;
   logic             reply_to_previous_device;
   logic             reply_from_next_device = 1'b0;
   logic [FM2_W-1:0] featuremap2;
   logic             finished_for_next_device;

   int vectors = 0;
   int miscompares = 0;

   logic [FM1_W-1:0] frame;
   logic [FM2_W-1:0] exp_q[$];
   logic [FM2_W-1:0] exp_fm;
   int               lat;
   int               replies;
   int               bad_cycles;

   maxpooling1 #(.bitwidth(BW)) dut (
      .clk                           (clk),
      .reset                         (reset),
      .featuremap1                   (featuremap1),
      .finished_from_previous_device (finished_from_previous_device),
      .reply_to_previous_device      (reply_to_previous_device),
      .reply_from_next_device        (reply_from_next_device),
      .featuremap2                   (featuremap2),
      .finished_for_next_device      (finished_for_next_device)
   );

   always #5 clk = ~clk;

   function automatic int o1(input int c, input int r, input int k);
      return (c*FM1_DIM*FM1_DIM + FM1_DIM*k + r)*BW;
   endfunction

   function automatic int o2(input int c, input int r, input int k);
      return (c*FM2_DIM*FM2_DIM + FM2_DIM*k + r)*BW;
   endfunction

   // Reference 2x2 signed max pooling over a whole frame
   function automatic logic [FM2_W-1:0] pool_model(input logic [FM1_W-1:0] f);
      logic [FM2_W-1:0]   res;
      logic signed [BW-1:0] best;
      logic signed [BW-1:0] v;
      res = '0;
      for (int c = 0; c < CHANNELS; c++)
         for (int r = 0; r < FM2_DIM; r++)
            for (int k = 0; k < FM2_DIM; k++) begin
               best = f[o1(c, 2*r, 2*k) +: BW];
               for (int dr = 0; dr < 2; dr++)
                  for (int dk = 0; dk < 2; dk++) begin
                     v = f[o1(c, 2*r+dr, 2*k+dk) +: BW];
                     if (v > best) best = v;
                  end
               res[o2(c, r, k) +: BW] = best;
            end
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_fm(input string tag, input logic [FM2_W-1:0] exp);
      int bad = 0;
      for (int i = 0; i < N_OUT; i++) begin
         if (featuremap2[i*BW +: BW] !== exp[i*BW +: BW]) begin
            bad = i;
            break;
         end
      end
      vectors++;
      assert (featuremap2 === exp) else begin
         miscompares++;
         $error("FAIL %s element %0d observed %h expected %h",
                tag, bad, featuremap2[bad*BW +: BW], exp[bad*BW +: BW]);
      end
   endtask

   task automatic check_scoreboard(input string tag);
      if (exp_q.size() == 0) begin
         check({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         exp_fm = exp_q.pop_front();
         check_fm(tag, exp_fm);
      end
   endtask

   // Called in the capture cycle; steps until finished rises (bounded)
   task automatic run_frame(output int n, output int extra_replies, input bit scramble);
      n = 0;
      extra_replies = 0;
      while (finished_for_next_device !== 1'b1 && n < 100) begin
         tick();
         n++;
         if (scramble && n == 1) featuremap1 = ~featuremap1;
         if (reply_to_previous_device === 1'b1) extra_replies++;
      end
   endtask

   task automatic random_frame();
      for (int i = 0; i < CHANNELS*FM1_DIM*FM1_DIM; i++) frame[i*BW +: BW] = $urandom;
   endtask

   initial begin
      // Reset
      tick();
      tick();
      check("rst_fm2_zero", {31'd0, featuremap2 === '0}, 32'd1);
      check("rst_reply", {31'd0, reply_to_previous_device}, 32'd0);
      check("rst_finished", {31'd0, finished_for_next_device}, 32'd0);
      reset = 1'b0;
      tick();
      check("idle_after_rst", {31'd0, finished_for_next_device | reply_to_previous_device}, 32'd0);

      // Ramp frame, upstream valid held high, input scrambled during pool
      for (int c = 0; c < CHANNELS; c++)
         for (int r = 0; r < FM1_DIM; r++)
            for (int k = 0; k < FM1_DIM; k++)
               frame[o1(c, r, k) +: BW] = (c == 0) ? 32'(FM1_DIM*r + k) : 32'(-(FM1_DIM*r + k));
      featuremap1 = frame;
      exp_q.push_back(pool_model(frame));
      finished_from_previous_device = 1'b1;
      tick();
      check("ramp_reply_capture", {31'd0, reply_to_previous_device}, 32'd1);
      run_frame(lat, replies, 1'b1);
      check("ramp_latency", 32'(lat), 32'd15);
      check("ramp_reply_once", 32'(replies), 32'd0);
      check_scoreboard("ramp_frame");
      check("ramp_ch0_0_0", featuremap2[o2(0, 0, 0) +: BW], 32'd29);
      check("ramp_ch0_13_13", featuremap2[o2(0, 13, 13) +: BW], 32'd783);
      check("ramp_ch1_0_0", featuremap2[o2(1, 0, 0) +: BW], 32'd0);
      check("ramp_ch1_6_3", featuremap2[o2(1, 6, 3) +: BW], 32'hFFFF_FEAA);

      // Hold off downstream for 50 cycles: output must stay put
      bad_cycles = 0;
      replies = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (finished_for_next_device !== 1'b1 || featuremap2 !== exp_fm) bad_cycles++;
         if (reply_to_previous_device !== 1'b0) replies++;
      end
      check("hold_stable_cycles", 32'(bad_cycles), 32'd0);
      check("hold_no_reply", 32'(replies), 32'd0);

      // Back-to-back frame with sign/tie windows planted
      random_frame();
      frame[o1(0, 0, 0) +: BW] = 32'hFFFF_FFFB;
      frame[o1(0, 0, 1) +: BW] = 32'hFFFF_FFFF;
      frame[o1(0, 1, 0) +: BW] = 32'hFFFF_FFFD;
      frame[o1(0, 1, 1) +: BW] = 32'hFFFF_FFFF;
      frame[o1(0, 2, 2) +: BW] = 32'h7FFF_FFFF;
      frame[o1(0, 2, 3) +: BW] = 32'h8000_0000;
      frame[o1(0, 3, 2) +: BW] = 32'h0000_0000;
      frame[o1(0, 3, 3) +: BW] = 32'h0000_0001;
      for (int dr = 0; dr < 2; dr++)
         for (int dk = 0; dk < 2; dk++) frame[o1(1, 26+dr, 26+dk) +: BW] = 32'd7;
      featuremap1 = frame;
      exp_q.push_back(pool_model(frame));
      reply_from_next_device = 1'b1;
      tick();
      check("b2b_reply_capture", {31'd0, reply_to_previous_device}, 32'd1);
      check("b2b_finished_drop", {31'd0, finished_for_next_device}, 32'd0);
      reply_from_next_device = 1'b0;
      finished_from_previous_device = 1'b0;
      run_frame(lat, replies, 1'b0);
      check("b2b_latency", 32'(lat), 32'd15);
      check_scoreboard("b2b_frame");
      check("sign_neg_window", featuremap2[o2(0, 0, 0) +: BW], 32'hFFFF_FFFF);
      check("sign_extreme_window", featuremap2[o2(0, 1, 1) +: BW], 32'h7FFF_FFFF);
      check("tie_window", featuremap2[o2(1, 13, 13) +: BW], 32'd7);
      reply_from_next_device = 1'b1;
      tick();
      check("release_to_idle", {31'd0, finished_for_next_device}, 32'd0);
      reply_from_next_device = 1'b0;
      tick();
      check("idle_no_capture", {31'd0, reply_to_previous_device}, 32'd0);

      // Reset in the middle of pooling (row 6)
      random_frame();
      featuremap1 = frame;
      finished_from_previous_device = 1'b1;
      tick();
      finished_from_previous_device = 1'b0;
      repeat (7) tick();
      check("midpool_not_done", {31'd0, finished_for_next_device}, 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_fm("midpool_rst_fm2", '0);
      check("midpool_rst_reply", {31'd0, reply_to_previous_device}, 32'd0);
      check("midpool_rst_finished", {31'd0, finished_for_next_device}, 32'd0);
      tick();
      check("midpool_stays_idle", {31'd0, finished_for_next_device | reply_to_previous_device}, 32'd0);

      // Fresh frame after reset; downstream ack asserted early must be ignored
      random_frame();
      featuremap1 = frame;
      exp_q.push_back(pool_model(frame));
      finished_from_previous_device = 1'b1;
      tick();
      check("post_rst_reply", {31'd0, reply_to_previous_device}, 32'd1);
      finished_from_previous_device = 1'b0;
      reply_from_next_device = 1'b1;
      run_frame(lat, replies, 1'b0);
      check("post_rst_latency", 32'(lat), 32'd15);
      check_scoreboard("post_rst_frame");
      tick();
      check("post_rst_release", {31'd0, finished_for_next_device}, 32'd0);
      reply_from_next_device = 1'b0;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
